// File: rtl/tx_pkg.sv
// Shared Tx-path definitions: framer FSM states and the CRC-16/CCITT-FALSE byte step.
package tx_pkg;

  typedef enum logic [2:0] {
    S_SYNC0,
    S_SYNC1,
    S_SEQ,
    S_PAY,
    S_CRC0,
    S_CRC1
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One byte of CRC-16, MSB first, no reflection, no final XOR.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16/CCITT-FALSE update for one byte per cycle; shared with the Rx deframer.
module crc16_ccitt_byte
  import tx_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  // Single-byte CRC step
  always_comb begin
    crc_next = crc16_byte(crc, data);
  end

endmodule

// File: rtl/tblk_crc_framer.sv
// Frames fixed-size payload blocks as SYNC(2) SEQ(1) payload CRC(2) toward the modulator.
// Payload passes through with zero latency; upstream is stalled during header and CRC bytes.
module tblk_crc_framer
  import tx_pkg::*;
#(
  parameter int unsigned size_tblck = 480,
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ival,
  input  logic [7:0] idata,
  output logic       oreq,
  input  logic       ireq,
  output logic       oval,
  output logic [7:0] odata
);

  localparam int unsigned CW = (size_tblck > 1) ? $clog2(size_tblck) : 1;
  localparam logic [CW-1:0] LAST = CW'(size_tblck - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [7:0]  seq;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        pay_beat;

  crc16_ccitt_byte u_crc (
    .crc      (crc),
    .data     (idata),
    .crc_next (crc_next)
  );

  assign pay_beat = (state == S_PAY) && ival && ireq;

  // Frame sequencing, payload byte count, sequence number and running CRC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SYNC0;
      cnt   <= '0;
      seq   <= '0;
      crc   <= CRC_INIT;
    end else begin
      unique case (state)
        S_SYNC0: if (ireq) state <= S_SYNC1;
        S_SYNC1: if (ireq) state <= S_SEQ;
        S_SEQ:   if (ireq) state <= S_PAY;
        S_PAY: begin
          if (pay_beat) begin
            crc <= crc_next;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_CRC0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_CRC0:  if (ireq) state <= S_CRC1;
        S_CRC1: begin
          if (ireq) begin
            state <= S_SYNC0;
            crc   <= CRC_INIT;
            seq   <= seq + 8'd1;
          end
        end
        default: state <= S_SYNC0;
      endcase
    end
  end

  // Output mux: header/CRC bytes from registers, payload straight through
  always_comb begin
    oval  = 1'b0;
    oreq  = 1'b0;
    odata = '0;
    if (!rst) begin
      unique case (state)
        S_SYNC0: begin oval = 1'b1; odata = SYNC_WORD[15:8]; end
        S_SYNC1: begin oval = 1'b1; odata = SYNC_WORD[7:0];  end
        S_SEQ:   begin oval = 1'b1; odata = seq;             end
        S_PAY: begin
          oval  = ival;
          odata = idata;
          oreq  = ireq;
        end
        S_CRC0:  begin oval = 1'b1; odata = crc[15:8]; end
        S_CRC1:  begin oval = 1'b1; odata = crc[7:0];  end
        default: begin oval = 1'b0; odata = '0; end
      endcase
    end
  end

endmodule

// File: tb/tb_tblk_crc_framer.sv
// Directed bench for tblk_crc_framer: check-value frame, seq increment/wrap, ireq stalls,
// ival gaps, mid-block reset, and a default-size all-zero block.
module tb_tblk_crc_framer;

  localparam int N     = 9;
  localparam int FLEN  = N + 5;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst, ival, ireq;
  logic [7:0] idata;
  logic       oreq, oval;
  logic [7:0] odata;

  logic       rst2, ival2, ireq2;
  logic [7:0] idata2;
  logic       oreq2, oval2;
  logic [7:0] odata2;

  int total = 0;
  int bad   = 0;

  logic [7:0] payload [0:N-1];

  always #5 clk = ~clk;

  tblk_crc_framer #(.size_tblck(N)) dut (
    .clk(clk), .rst(rst), .ival(ival), .idata(idata),
    .oreq(oreq), .ireq(ireq), .oval(oval), .odata(odata)
  );

  tblk_crc_framer dut480 (
    .clk(clk), .rst(rst2), .ival(ival2), .idata(idata2),
    .oreq(oreq2), .ireq(ireq2), .oval(oval2), .odata(odata2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial LFSR reference, fed one data bit at a time
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = c[15] ^ d[b];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [15:0] payload_crc();
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < N; i++) c = ref_crc(c, payload[i]);
    return c;
  endfunction

  task automatic load_check_payload();
    for (int i = 0; i < N; i++) payload[i] = 8'h31 + 8'(i);
  endtask

  // Runs one frame on the small DUT; called at posedge+1.
  // poff: % cycles with ireq low, pgap: % payload cycles with ival low,
  // abort_at: frame index at which rst is asserted (-1 = never).
  task automatic run_block(input logic [7:0] seq_exp, input logic [15:0] crc_exp,
                           input int poff, input int pgap, input int abort_at);
    int idx = 0;
    int cyc = 0;
    logic in_pay, beat;
    logic [7:0] eb;
    while (idx < FLEN && cyc < LIMIT) begin
      in_pay = (idx >= 3) && (idx < 3 + N);
      ireq   = ($urandom_range(99) >= poff);
      ival   = in_pay ? ($urandom_range(99) >= pgap) : 1'($urandom_range(1));
      idata  = in_pay ? payload[idx-3] : 8'hEE;
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_oval", oval, 0);
        chk("abort_oreq", oreq, 0);
        chk("abort_odata", odata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      case (idx)
        0:       eb = 8'hA5;
        1:       eb = 8'hC3;
        2:       eb = seq_exp;
        FLEN-2:  eb = crc_exp[15:8];
        FLEN-1:  eb = crc_exp[7:0];
        default: eb = payload[idx-3];
      endcase
      #1;
      if (in_pay) begin
        chk("pay_oval", oval, ival);
        chk("pay_oreq", oreq, ireq);
        if (ival) chk("pay_byte", odata, eb);
        beat = ival & ireq;
      end else begin
        chk("hdr_oval", oval, 1);
        chk("hdr_oreq", oreq, 0);
        chk(idx < 3 ? "hdr_byte" : "crc_byte", odata, eb);
        beat = ireq;
      end
      @(posedge clk); #1;
      if (beat) idx++;
      cyc++;
    end
    if (idx < FLEN) chk("frame_timeout", idx, FLEN);
  endtask

  initial begin
    logic [15:0] c480;
    logic [7:0]  e2;
    rst = 1'b1; ival = 1'b0; ireq = 1'b1; idata = 8'h00;
    rst2 = 1'b1; ival2 = 1'b0; ireq2 = 1'b1; idata2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    ival = 1'b1; idata = 8'h55;
    #1;
    chk("rst_oval", oval, 0);
    chk("rst_oreq", oreq, 0);
    chk("rst_odata", odata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Check-value frame, then back-to-back identical payload with ireq stalls
    load_check_payload();
    run_block(8'h00, 16'h29B1, 0, 0, -1);
    run_block(8'h01, 16'h29B1, 30, 0, -1);

    // Different payload with ival gaps and ireq stalls
    for (int i = 0; i < N; i++) payload[i] = 8'(i * 37 + 5);
    run_block(8'h02, payload_crc(), 30, 40, -1);

    // Reset after 4 payload bytes, then a fresh frame from seq 0
    load_check_payload();
    run_block(8'h03, 16'h29B1, 0, 0, 7);
    run_block(8'h00, 16'h29B1, 0, 0, -1);

    // Blocks 2..256 then block 257 wraps to seq 0
    for (int s = 1; s < 256; s++) run_block(8'(s), 16'h29B1, 0, 0, -1);
    run_block(8'h00, 16'h29B1, 20, 0, -1);

    // Default block size, upstream idle padding (zero bytes)
    c480 = 16'hFFFF;
    for (int i = 0; i < 480; i++) c480 = ref_crc(c480, 8'h00);
    @(posedge clk); #1;
    rst2 = 1'b0; ival2 = 1'b1; ireq2 = 1'b1; idata2 = 8'h00;
    for (int i = 0; i < 486; i++) begin
      if (i == 0 || i == 485) e2 = 8'hA5;
      else if (i == 1)        e2 = 8'hC3;
      else if (i == 2)        e2 = 8'h00;
      else if (i == 483)      e2 = c480[15:8];
      else if (i == 484)      e2 = c480[7:0];
      else                    e2 = 8'h00;
      #1;
      chk("b480_oval", oval2, 1);
      chk("b480_oreq", oreq2, (i >= 3 && i < 483) ? 1 : 0);
      chk("b480_byte", odata2, e2);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
